shift_in_reg: RTL and testbench
===============================

SHIFT_IN_REG -- requirements
Module: shift_in_reg

Interface
REQ-001 The block SHALL have one parameter: SEG_INV, default 1, 1 = segment outputs active-low, 0 = active-high.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port but_1, input, 1 bit: "shift" button, active-low (pressed = 0).
REQ-005 The block SHALL have the port but_2, input, 1 bit: "abort" button, active-low.
REQ-006 The block SHALL have the port sw, input, 8 bits: only sw[0] is used, as the serial data bit; sw[7:1] are ignored.
REQ-007 The block SHALL have the port led7, output, 8 bits: live shift register contents.
REQ-008 The block SHALL have the port gled7, output, 8 bits: last committed byte.
REQ-009 The block SHALL have the ports seg7_a and seg7_b, outputs, 7 bits each: hex display of gled7[3:0] and gled7[7:4], in the team's standard 0-F font.
REQ-010 The block SHALL have the port cnt, output, 4 bits: number of bits received in the current frame.
REQ-011 The block SHALL have the ports rdy and err, outputs, 1 bit each: frame committed, and parity error.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer (r, rr); the push pulse SHALL be rr & ~r, one cycle wide per press.
REQ-013 The register update for a push SHALL occur on the 2nd rising edge after the button is first sampled low; holding a button SHALL produce exactly one action.
REQ-014 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 A shift push in IDLE or SHIFT SHALL perform sreg <= {sw[0], sreg[7:1]} (LSB first), increment cnt and enter SHIFT.
REQ-016 When cnt reaches 8, with PARITY_EN undefined, the same edge SHALL commit gled7 <= the new sreg, set rdy=1 and enter DONE.
REQ-017 A shift push in DONE SHALL start a new frame: sreg <= {sw[0], 7'b0}, cnt <= 1, rdy <= 0, err <= 0, state SHIFT.
REQ-018 An abort push in any state SHALL clear sreg, cnt, rdy and err and enter IDLE; gled7 SHALL be retained.
REQ-019 When abort and shift pushes occur in the same cycle, abort SHALL win and the shift SHALL be discarded.
REQ-020 The seg7 outputs SHALL be combinational from gled7 and SHALL be inverted when SEG_INV=1.
REQ-021 cnt SHALL never exceed the frame length (8, or 9 with PARITY_EN).

Reset
REQ-022 reset=0 SHALL immediately force sreg=0, gled7=0, cnt=0, rdy=0, err=0, state IDLE and synchronizer flops =1, independent of clk.
REQ-023 After reset, seg7_a and seg7_b SHALL both show "0" (7'b1000000 when SEG_INV=1).
REQ-024 A reset asserted mid-frame SHALL discard the partial frame with no commit.

Configuration
REQ-025 With macro SHIFT_IN_PARITY_EN defined, a frame SHALL be 9 bits: 8 data bits LSB first, then 1 even-parity bit.
REQ-026 The parity bit SHALL NOT enter sreg; on the 9th push, if XOR(data, parity)=0 the block SHALL commit with rdy=1, otherwise it SHALL set err=1, make no commit and leave gled7 unchanged; both cases SHALL enter DONE.
REQ-027 With SHIFT_IN_PARITY_EN undefined, the frame SHALL be 8 bits and err SHALL be tied to 0.

Verification
REQ-028 The bench SHALL cover: reset, then 8 shift pushes with sw[0] = 1,0,1,0,0,1,0,1 -> gled7=0xA5, rdy=1, cnt=8, seg7_a=7'b0010010, seg7_b=7'b0001000.
REQ-029 The bench SHALL cover: after committing 0xA5, 3 pushes with sw[0]=1 then an abort -> led7=0x00, cnt=0, rdy=0, gled7=0xA5.
REQ-030 The bench SHALL cover: but_1 held low for 100 cycles -> cnt increments by exactly 1; abort and shift pushed in the same cycle -> cnt=0, sreg=0.
REQ-031 The bench SHALL cover: reset asserted between clock edges after 5 bits -> all outputs at reset values before the next clk edge.
REQ-032 The bench SHALL cover, with SHIFT_IN_PARITY_EN: 0xA5 then parity 0 -> gled7=0xA5, rdy=1; 0x3C then parity 1 -> err=1, rdy=0, gled7 still 0xA5.

Source files
------------

// File: rtl/shift_in_reg.sv
// Serial shift-in register: debounced-by-sync buttons shift sw[0] in LSB first and commit a byte.
// Optional even-parity framing is enabled by defining SHIFT_IN_PARITY_EN.
module shift_in_reg #(
    parameter bit SEG_INV = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       but_1,
    input  logic       but_2,
    input  logic [7:0] sw,
    output logic [7:0] led7,
    output logic [7:0] gled7,
    output logic [6:0] seg7_a,
    output logic [6:0] seg7_b,
    output logic [3:0] cnt,
    output logic       rdy,
    output logic       err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state;
    logic [7:0] sreg;
    logic [7:0] gled;
    logic [7:0] sreg_shift;
    logic       b1_r, b1_rr, b2_r, b2_rr;
    logic       shift_push, abort_push;
    logic       unused_sw;

    assign unused_sw = ^sw[7:1];

    // Buttons idle high, so the synchronizer flops reset to 1 to avoid a spurious push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b1_r  <= 1'b1;
            b1_rr <= 1'b1;
            b2_r  <= 1'b1;
            b2_rr <= 1'b1;
        end else begin
            b1_r  <= but_1;
            b1_rr <= b1_r;
            b2_r  <= but_2;
            b2_rr <= b2_r;
        end
    end

    assign shift_push = b1_rr & ~b1_r;
    assign abort_push = b2_rr & ~b2_r;
    assign sreg_shift = {sw[0], sreg[7:1]};

`ifdef SHIFT_IN_PARITY_EN
    logic parity_bad;
    logic err_q;

    assign parity_bad = ^{sreg, sw[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (abort_push) begin
            err_q <= 1'b0;
        end else if (shift_push) begin
            if (state == DONE) begin
                err_q <= 1'b0;
            end else if (cnt == 4'd8 && parity_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Abort is checked first so a simultaneous shift is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= 8'h00;
            gled  <= 8'h00;
            cnt   <= 4'd0;
            rdy   <= 1'b0;
        end else if (abort_push) begin
            state <= IDLE;
            sreg  <= 8'h00;
            cnt   <= 4'd0;
            rdy   <= 1'b0;
        end else if (shift_push) begin
            if (state == DONE) begin
                sreg  <= {sw[0], 7'b0};
                cnt   <= 4'd1;
                rdy   <= 1'b0;
                state <= SHIFT;
            end
`ifdef SHIFT_IN_PARITY_EN
            else if (cnt == 4'd8) begin
                if (!parity_bad) begin
                    gled <= sreg;
                    rdy  <= 1'b1;
                end
                cnt   <= 4'd9;
                state <= DONE;
            end
`endif
            else begin
                sreg <= sreg_shift;
                cnt  <= cnt + 4'd1;
`ifdef SHIFT_IN_PARITY_EN
                state <= SHIFT;
`else
                if (cnt == 4'd7) begin
                    gled  <= sreg_shift;
                    rdy   <= 1'b1;
                    state <= DONE;
                end else begin
                    state <= SHIFT;
                end
`endif
            end
        end
    end

    // Font is stored active-high (bit order g..a) and flipped for common-anode displays.
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'b0111111;
            4'h1: hex_font = 7'b0000110;
            4'h2: hex_font = 7'b1011011;
            4'h3: hex_font = 7'b1001111;
            4'h4: hex_font = 7'b1100110;
            4'h5: hex_font = 7'b1101101;
            4'h6: hex_font = 7'b1111101;
            4'h7: hex_font = 7'b0000111;
            4'h8: hex_font = 7'b1111111;
            4'h9: hex_font = 7'b1101111;
            4'hA: hex_font = 7'b1110111;
            4'hB: hex_font = 7'b1111100;
            4'hC: hex_font = 7'b0111001;
            4'hD: hex_font = 7'b1011110;
            4'hE: hex_font = 7'b1111001;
            default: hex_font = 7'b1110001;
        endcase
    endfunction

    assign seg7_a = SEG_INV ? ~hex_font(gled[3:0]) : hex_font(gled[3:0]);
    assign seg7_b = SEG_INV ? ~hex_font(gled[7:4]) : hex_font(gled[7:4]);

    assign led7  = sreg;
    assign gled7 = gled;

endmodule

// File: tb/tb_shift_in_reg.sv
// Scoreboard bench for shift_in_reg: a reference model queues expected snapshots per push.
// Build with SHIFT_IN_PARITY_EN defined to also exercise the 9-bit parity frame.
module tb_shift_in_reg;

`ifdef SHIFT_IN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] led;
        logic [7:0] gled;
        logic [3:0] cnt;
        logic       rdy;
        logic       err;
    } snap_t;

    logic       clk;
    logic       reset;
    logic       but_1;
    logic       but_2;
    logic [7:0] sw;
    logic [7:0] led7;
    logic [7:0] gled7;
    logic [6:0] seg7_a;
    logic [6:0] seg7_b;
    logic [3:0] cnt;
    logic       rdy;
    logic       err;

    int    test_count = 0;
    int    fail_count = 0;
    snap_t exp_q[$];
    snap_t exp_s;
    snap_t obs_s;

    logic [7:0] m_sreg;
    logic [7:0] m_gled;
    logic [3:0] m_cnt;
    logic       m_rdy;
    logic       m_err;
    logic       m_done;

    shift_in_reg #(.SEG_INV(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .but_1  (but_1),
        .but_2  (but_2),
        .sw     (sw),
        .led7   (led7),
        .gled7  (gled7),
        .seg7_a (seg7_a),
        .seg7_b (seg7_b),
        .cnt    (cnt),
        .rdy    (rdy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic snap_t dut_snap();
        dut_snap = '{led: led7, gled: gled7, cnt: cnt, rdy: rdy, err: err};
    endfunction

    function automatic snap_t model_snap();
        model_snap = '{led: m_sreg, gled: m_gled, cnt: m_cnt, rdy: m_rdy, err: m_err};
    endfunction

    task automatic model_reset();
        m_sreg = 8'h00;
        m_gled = 8'h00;
        m_cnt  = 4'd0;
        m_rdy  = 1'b0;
        m_err  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit sh, input bit ab, input bit d);
        if (ab) begin
            m_sreg = 8'h00;
            m_cnt  = 4'd0;
            m_rdy  = 1'b0;
            m_err  = 1'b0;
            m_done = 1'b0;
        end else if (sh) begin
            if (m_done) begin
                m_sreg = {d, 7'b0};
                m_cnt  = 4'd1;
                m_rdy  = 1'b0;
                m_err  = 1'b0;
                m_done = 1'b0;
            end else if (PAR && m_cnt == 4'd8) begin
                if ((^m_sreg) == d) begin
                    m_gled = m_sreg;
                    m_rdy  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_cnt  = 4'd9;
                m_done = 1'b1;
            end else begin
                m_sreg = {d, m_sreg[7:1]};
                m_cnt  = m_cnt + 4'd1;
                if (!PAR && m_cnt == 4'd8) begin
                    m_gled = m_sreg;
                    m_rdy  = 1'b1;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    // One press-and-release; the expected snapshot is queued as the press is driven.
    task automatic do_push(input bit sh, input bit ab, input bit d);
        @(negedge clk);
        sw[0] = d;
        but_1 = ~sh;
        but_2 = ~ab;
        model_step(sh, ab, d);
        exp_q.push_back(model_snap());
        repeat (3) @(negedge clk);
        but_1 = 1'b1;
        but_2 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        but_1 = 1'b1;
        but_2 = 1'b1;
        sw    = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        test_count++;
        if (dut_snap() !== model_snap())
            $display("[TB] FAIL reset_state: got %h expected %h", dut_snap(), model_snap());
        test_count++;
        if (seg7_a !== 7'b1000000 || seg7_b !== 7'b1000000) begin
            fail_count++;
            $display("[TB] FAIL reset_seg: got a=%b b=%b expected 1000000", seg7_a, seg7_b);
        end
        if (dut_snap() !== model_snap()) fail_count++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        bit bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            do_push(1'b1, 1'b0, bits[i]);
            exp_s = exp_q.pop_front();
            obs_s = dut_snap();
            test_count++;
            if (obs_s !== exp_s) begin
                fail_count++;
                $display("[TB] FAIL frame_bit%0d: got %h expected %h", i, obs_s, exp_s);
            end
        end
        if (PAR) begin
            do_push(1'b1, 1'b0, 1'b0);
            exp_s = exp_q.pop_front();
            obs_s = dut_snap();
            test_count++;
            if (obs_s !== exp_s) begin
                fail_count++;
                $display("[TB] FAIL frame_parity: got %h expected %h", obs_s, exp_s);
            end
        end
        test_count++;
        if (gled7 !== 8'hA5 || rdy !== 1'b1 || cnt !== (PAR ? 4'd9 : 4'd8)) begin
            fail_count++;
            $display("[TB] FAIL frame_commit: got gled7=%h rdy=%b cnt=%0d expected A5 1 %0d",
                     gled7, rdy, cnt, PAR ? 9 : 8);
        end
        test_count++;
        if (seg7_a !== 7'b0010010 || seg7_b !== 7'b0001000) begin
            fail_count++;
            $display("[TB] FAIL frame_seg: got a=%b b=%b expected 0010010 0001000", seg7_a, seg7_b);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) begin
            do_push(1'b1, 1'b0, 1'b1);
            exp_s = exp_q.pop_front();
            obs_s = dut_snap();
            test_count++;
            if (obs_s !== exp_s) begin
                fail_count++;
                $display("[TB] FAIL abort_pre%0d: got %h expected %h", i, obs_s, exp_s);
            end
        end
        do_push(1'b0, 1'b1, 1'b0);
        exp_s = exp_q.pop_front();
        obs_s = dut_snap();
        test_count++;
        if (obs_s !== exp_s) begin
            fail_count++;
            $display("[TB] FAIL abort_clear: got %h expected %h", obs_s, exp_s);
        end
        test_count++;
        if (led7 !== 8'h00 || cnt !== 4'd0 || rdy !== 1'b0 || gled7 !== 8'hA5) begin
            fail_count++;
            $display("[TB] FAIL abort_keep: got led7=%h cnt=%0d rdy=%b gled7=%h expected 00 0 0 A5",
                     led7, cnt, rdy, gled7);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        sw[0] = 1'b1;
        but_1 = 1'b0;
        model_step(1'b1, 1'b0, 1'b1);
        exp_q.push_back(model_snap());
        repeat (100) @(negedge clk);
        but_1 = 1'b1;
        repeat (3) @(negedge clk);
        exp_s = exp_q.pop_front();
        obs_s = dut_snap();
        test_count++;
        if (obs_s !== exp_s) begin
            fail_count++;
            $display("[TB] FAIL hold_single: got %h expected %h", obs_s, exp_s);
        end
        test_count++;
        if (cnt !== 4'd1) begin
            fail_count++;
            $display("[TB] FAIL hold_cnt: got %0d expected 1", cnt);
        end
    endtask

    task automatic test_abort_wins();
        do_push(1'b1, 1'b1, 1'b1);
        exp_s = exp_q.pop_front();
        obs_s = dut_snap();
        test_count++;
        if (obs_s !== exp_s) begin
            fail_count++;
            $display("[TB] FAIL abort_wins: got %h expected %h", obs_s, exp_s);
        end
        test_count++;
        if (cnt !== 4'd0 || led7 !== 8'h00) begin
            fail_count++;
            $display("[TB] FAIL abort_wins_regs: got cnt=%0d led7=%h expected 0 00", cnt, led7);
        end
    endtask

    task automatic test_reset_mid();
        bit bits [5] = '{1, 1, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            do_push(1'b1, 1'b0, bits[i]);
            exp_s = exp_q.pop_front();
            obs_s = dut_snap();
            test_count++;
            if (obs_s !== exp_s) begin
                fail_count++;
                $display("[TB] FAIL mid_bit%0d: got %h expected %h", i, obs_s, exp_s);
            end
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        test_count++;
        if (dut_snap() !== model_snap()) begin
            fail_count++;
            $display("[TB] FAIL mid_reset: got %h expected %h", dut_snap(), model_snap());
        end
        test_count++;
        if (seg7_a !== 7'b1000000 || seg7_b !== 7'b1000000) begin
            fail_count++;
            $display("[TB] FAIL mid_reset_seg: got a=%b b=%b expected 1000000", seg7_a, seg7_b);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef SHIFT_IN_PARITY_EN
    task automatic test_parity();
        logic [7:0] frames [2] = '{8'hA5, 8'h3C};
        bit         par    [2] = '{0, 1};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                do_push(1'b1, 1'b0, frames[f][i]);
                void'(exp_q.pop_front());
            end
            do_push(1'b1, 1'b0, par[f]);
            exp_s = exp_q.pop_front();
            obs_s = dut_snap();
            test_count++;
            if (obs_s !== exp_s) begin
                fail_count++;
                $display("[TB] FAIL parity_frame%0d: got %h expected %h", f, obs_s, exp_s);
            end
        end
        test_count++;
        if (err !== 1'b1 || rdy !== 1'b0 || gled7 !== 8'hA5) begin
            fail_count++;
            $display("[TB] FAIL parity_err: got err=%b rdy=%b gled7=%h expected 1 0 A5",
                     err, rdy, gled7);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_abort();
        test_hold();
        test_abort_wins();
        test_reset_mid();
`ifdef SHIFT_IN_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
